// File: rtl/rf_write_arbiter_if.sv
// Writeback request / register-file write bundle for rf_write_arbiter.
// slave = arbiter side, master = requester and register-file side.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] wv;
  logic              rw;
  logic [31:0]       busy;

  modport slave (
    input  a_valid, a_reg, a_data,
    input  m_valid, m_reg, m_data,
    output a_ready, m_ready,
    output wr, wv, rw, busy
  );

  modport master (
    output a_valid, a_reg, a_data,
    output m_valid, m_reg, m_data,
    input  a_ready, m_ready,
    input  wr, wv, rw, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with pending-write scoreboard.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin on contention (else M wins).
module rf_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic             clock,
  input logic             reset,
  rf_write_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};

  logic              r_a_full;
  logic [ADDR_W-1:0] r_a_reg;
  logic [DATA_W-1:0] r_a_data;
  logic              r_m_full;
  logic [ADDR_W-1:0] r_m_reg;
  logic [DATA_W-1:0] r_m_data;
  logic [ADDR_W-1:0] r_wr;
  logic [DATA_W-1:0] r_wv;
  logic              r_rw;
  logic [31:0]       r_busy;

  logic              w_a_acc;
  logic              w_m_acc;
  logic              w_a_keep;
  logic              w_m_keep;
  logic              w_gnt_a;
  logic              w_gnt_m;
  logic [31:0]       w_busy_nxt;

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic              r_ptr;
`endif

  assign w_a_acc  = bus.a_valid & ~r_a_full;
  assign w_m_acc  = bus.m_valid & ~r_m_full;
  assign w_a_keep = w_a_acc & (bus.a_reg != XZR);
  assign w_m_keep = w_m_acc & (bus.m_reg != XZR);

  assign bus.a_ready = ~r_a_full;
  assign bus.m_ready = ~r_m_full;
  assign bus.wr      = r_wr;
  assign bus.wv      = r_wv;
  assign bus.rw      = r_rw;
  assign bus.busy    = r_busy;

  // Pick one full buffer; contention resolved by pointer or M priority.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_m = 1'b0;
    if (r_a_full && r_m_full) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      w_gnt_a = ~r_ptr;
      w_gnt_m = r_ptr;
`else
      w_gnt_m = 1'b1;
`endif
    end else begin
      w_gnt_a = r_a_full;
      w_gnt_m = r_m_full;
    end
  end

  // Scoreboard: clear the committing register, then set wins on overlap.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rw)
      w_busy_nxt[r_wr] = 1'b0;
    if (w_a_keep)
      w_busy_nxt[bus.a_reg] = 1'b1;
    if (w_m_keep)
      w_busy_nxt[bus.m_reg] = 1'b1;
  end

  // Single-entry buffers; accept and grant never coincide on one buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_full <= 1'b0;
      r_a_reg  <= '0;
      r_a_data <= '0;
      r_m_full <= 1'b0;
      r_m_reg  <= '0;
      r_m_data <= '0;
    end else begin
      if (w_a_keep) begin
        r_a_full <= 1'b1;
        r_a_reg  <= bus.a_reg;
        r_a_data <= bus.a_data;
      end else if (w_gnt_a) begin
        r_a_full <= 1'b0;
      end
      if (w_m_keep) begin
        r_m_full <= 1'b1;
        r_m_reg  <= bus.m_reg;
        r_m_data <= bus.m_data;
      end else if (w_gnt_m) begin
        r_m_full <= 1'b0;
      end
    end
  end

  // Register-file write port; wr/wv hold when no grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rw <= 1'b0;
      r_wr <= '0;
      r_wv <= '0;
    end else begin
      r_rw <= w_gnt_a | w_gnt_m;
      if (w_gnt_a) begin
        r_wr <= r_a_reg;
        r_wv <= r_a_data;
      end else if (w_gnt_m) begin
        r_wr <= r_m_reg;
        r_wv <= r_m_data;
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

`ifdef RF_ARB_ROUND_ROBIN_EN
  // Pointer moves only when both buffers competed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ptr <= 1'b0;
    else if (r_a_full && r_m_full)
      r_ptr <= ~r_ptr;
  end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
// Expected values are hand-derived per step; RF_ARB_ROUND_ROBIN_EN aware.
module tb_rf_write_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  rf_write_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
  endtask

  int a_acc;
  int m_acc;
  int n_rw;
  int n_rw_loop;
  int n_w1;
  int n_w2;
  int n_same;
  logic [4:0] first_r;
  logic [4:0] second_r;

  initial begin
    bus.a_valid = 1'b0;
    bus.a_reg   = '0;
    bus.a_data  = '0;
    bus.m_valid = 1'b0;
    bus.m_reg   = '0;
    bus.m_data  = '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
    first_r  = 5'd5;
    second_r = 5'd6;
`else
    first_r  = 5'd6;
    second_r = 5'd5;
`endif

    step();
    step();
    chk("rst_rw", 64'(bus.rw), 64'd0);
    chk("rst_wr", 64'(bus.wr), 64'd0);
    chk("rst_wv", bus.wv, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ardy", 64'(bus.a_ready), 64'd1);
    chk("rst_mrdy", 64'(bus.m_ready), 64'd1);
    reset = 1'b0;
    step();

    // Single ALU write to r3
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd3;
    bus.a_data  = 64'h1234;
    step();
    idle();
    chk("t1_e1_busy", 64'(bus.busy), 64'h8);
    chk("t1_e1_rw", 64'(bus.rw), 64'd0);
    chk("t1_e1_ardy", 64'(bus.a_ready), 64'd0);
    step();
    chk("t1_e2_rw", 64'(bus.rw), 64'd1);
    chk("t1_e2_wr", 64'(bus.wr), 64'd3);
    chk("t1_e2_wv", bus.wv, 64'h1234);
    chk("t1_e2_busy", 64'(bus.busy), 64'h8);
    chk("t1_e2_ardy", 64'(bus.a_ready), 64'd1);
    step();
    chk("t1_e3_busy", 64'(bus.busy), 64'd0);
    chk("t1_e3_rw", 64'(bus.rw), 64'd0);
    chk("t1_e3_wv_hold", bus.wv, 64'h1234);

    // Load to XZR is swallowed
    bus.m_valid = 1'b1;
    bus.m_reg   = 5'd31;
    bus.m_data  = 64'hFF;
    step();
    idle();
    chk("t2_mrdy", 64'(bus.m_ready), 64'd1);
    chk("t2_busy", 64'(bus.busy), 64'd0);
    chk("t2_rw_e1", 64'(bus.rw), 64'd0);
    step();
    chk("t2_rw_e2", 64'(bus.rw), 64'd0);
    step();
    chk("t2_rw_e3", 64'(bus.rw), 64'd0);
    chk("t2_busy_e3", 64'(bus.busy), 64'd0);

    // Contended same-edge accept
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd5;
    bus.a_data  = 64'hA;
    bus.m_valid = 1'b1;
    bus.m_reg   = 5'd6;
    bus.m_data  = 64'hB;
    step();
    idle();
    chk("t3_busy_e1", 64'(bus.busy), 64'h60);
    chk("t3_ardy_e1", 64'(bus.a_ready), 64'd0);
    chk("t3_mrdy_e1", 64'(bus.m_ready), 64'd0);
    step();
    chk("t3_rw_e2", 64'(bus.rw), 64'd1);
    chk("t3_wr_e2", 64'(bus.wr), 64'(first_r));
    chk("t3_wv_e2", bus.wv, 64'(first_r) + 64'd5);
    chk("t3_busy_e2", 64'(bus.busy), 64'h60);
    step();
    chk("t3_rw_e3", 64'(bus.rw), 64'd1);
    chk("t3_wr_e3", 64'(bus.wr), 64'(second_r));
    chk("t3_wv_e3", bus.wv, 64'(second_r) + 64'd5);
    chk("t3_busy_e3", 64'(bus.busy), 64'd1 << second_r);
    step();
    chk("t3_rw_e4", 64'(bus.rw), 64'd0);
    chk("t3_busy_e4", 64'(bus.busy), 64'd0);

    // Re-issue to r7 on the commit edge keeps busy set
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd7;
    bus.a_data  = 64'h1;
    step();
    idle();
    step();
    chk("t4_rw_e2", 64'(bus.rw), 64'd1);
    chk("t4_wv_e2", bus.wv, 64'h1);
    chk("t4_ardy_e2", 64'(bus.a_ready), 64'd1);
    bus.a_valid = 1'b1;
    bus.a_data  = 64'h2;
    step();
    idle();
    chk("t4_busy_e3", 64'(bus.busy), 64'h80);
    chk("t4_rw_e3", 64'(bus.rw), 64'd0);
    chk("t4_ardy_e3", 64'(bus.a_ready), 64'd0);
    step();
    chk("t4_rw_e4", 64'(bus.rw), 64'd1);
    chk("t4_wr_e4", 64'(bus.wr), 64'd7);
    chk("t4_wv_e4", bus.wv, 64'h2);
    chk("t4_busy_e4", 64'(bus.busy), 64'h80);
    step();
    chk("t4_busy_e5", 64'(bus.busy), 64'd0);

    // Both requesters streaming
    a_acc = 0;
    m_acc = 0;
    n_rw = 0;
    n_rw_loop = 0;
    n_w1 = 0;
    n_w2 = 0;
    n_same = 0;
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd1;
    bus.a_data  = 64'h11;
    bus.m_valid = 1'b1;
    bus.m_reg   = 5'd2;
    bus.m_data  = 64'h22;
    for (int i = 1; i <= 10; i++) begin
      if (bus.a_ready) a_acc++;
      if (bus.m_ready) m_acc++;
      step();
      if (bus.rw) begin
        n_rw++;
        if (i >= 2) n_rw_loop++;
        if (bus.wr == 5'd1) n_w1++;
        if (bus.wr == 5'd2) n_w2++;
      end
      if (i >= 2 && bus.a_ready == bus.m_ready) n_same++;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.rw) begin
        n_rw++;
        if (bus.wr == 5'd1) n_w1++;
        if (bus.wr == 5'd2) n_w2++;
      end
    end
    chk("t5_a_acc", 64'(a_acc), 64'd5);
    chk("t5_m_acc", 64'(m_acc), 64'd5);
    chk("t5_rw_every", 64'(n_rw_loop), 64'd9);
    chk("t5_rw_total", 64'(n_rw), 64'd10);
    chk("t5_w1", 64'(n_w1), 64'd5);
    chk("t5_w2", 64'(n_w2), 64'd5);
    chk("t5_rdy_alt", 64'(n_same), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);

    // Reset with a write in flight and a buffer still full
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd10;
    bus.a_data  = 64'hAA;
    bus.m_valid = 1'b1;
    bus.m_reg   = 5'd11;
    bus.m_data  = 64'hBB;
    step();
    idle();
    step();
    chk("t6_rw_pre", 64'(bus.rw), 64'd1);
    chk("t6_one_full", 64'(bus.a_ready ^ bus.m_ready), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rw_async", 64'(bus.rw), 64'd0);
    chk("t6_busy_async", 64'(bus.busy), 64'd0);
    chk("t6_wr_async", 64'(bus.wr), 64'd0);
    chk("t6_wv_async", bus.wv, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("t6_rw_post", 64'(bus.rw), 64'd0);
    chk("t6_ardy_post", 64'(bus.a_ready), 64'd1);
    chk("t6_mrdy_post", 64'(bus.m_ready), 64'd1);
    step();
    chk("t6_rw_post2", 64'(bus.rw), 64'd0);
    chk("t6_wv_post2", bus.wv, 64'd0);
    chk("t6_busy_post2", 64'(bus.busy), 64'd0);

    // Contention right after reset restarts pointer at A
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd5;
    bus.a_data  = 64'hA;
    bus.m_valid = 1'b1;
    bus.m_reg   = 5'd6;
    bus.m_data  = 64'hB;
    step();
    idle();
    step();
    chk("t7_wr_e2", 64'(bus.wr), 64'(first_r));
    step();
    chk("t7_wr_e3", 64'(bus.wr), 64'(second_r));
    step();
    chk("t7_busy_e4", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a_valid input 1, a_ready output 1, a_reg input ADDR_W, a_data input DATA_W: ALU writeback requester.
REQ-006 SHALL have ports m_valid input 1, m_ready output 1, m_reg input ADDR_W, m_data input DATA_W: memory-load writeback requester.
REQ-007 SHALL have ports wr output ADDR_W, wv output DATA_W, rw output 1: register-file write port drive, all registered.
REQ-008 SHALL have port busy  output 32  per-register pending-write scoreboard, registered.

Function
REQ-009 SHALL hold one single-entry buffer per requester (A, M); x_ready = 1 exactly when that buffer is empty.
REQ-010 SHALL accept a request on a rising edge where x_valid && x_ready; x_reg/x_data are captured into the buffer.
REQ-011 SHALL accept a request with x_reg == 31 (XZR) but discard it: buffer stays empty, busy unchanged, no write issued.
REQ-012 SHALL set busy[x_reg] on the accepting edge for x_reg != 31.
REQ-013 SHALL, on each edge where at least one buffer is full, grant exactly one buffer, empty it, and load wr/wv with its contents and rw = 1 for the following cycle.
REQ-014 SHALL drive rw = 0 in any cycle following an edge with no grant; wr/wv hold their last values.
REQ-015 SHALL clear busy[wr] on the edge where rw == 1 (the register-file write edge).
REQ-016 SHALL give set priority when busy set (REQ-012) and clear (REQ-015) target the same register on the same edge.
REQ-017 Latency: accept at edge N, earliest grant at edge N+1, register-file write and busy clear at edge N+2.
REQ-018 A granted buffer SHALL be able to accept a new request on the same edge it is emptied only on the following edge (ready is a pure function of buffer state; no bypass).
REQ-019 Sustained throughput SHALL be one write per cycle; with both requesters streaming, each is limited to one accept per two cycles.
REQ-020 Ordering of two buffered writes to the same register SHALL follow grant order; preventing such conflicts is the requesters' duty, using busy.

Reset
REQ-021 On reset SHALL asynchronously empty both buffers, set rw = 0, wr = 0, wv = 0, busy = 0, and round-robin pointer to A.
REQ-022 Reset mid-operation SHALL drop all buffered and in-flight writes; rw SHALL be 0 on the first edge after reset deasserts, with a_ready = m_ready = 1.

Configuration
REQ-023 With RF_ARB_ROUND_ROBIN_EN defined, when both buffers are full, grant SHALL alternate, starting with A after reset; the pointer advances only on contended grants.
REQ-024 Without RF_ARB_ROUND_ROBIN_EN, when both buffers are full, M SHALL always be granted (fixed priority); the pointer logic is absent.

Verification
REQ-025 Reset, then a_valid=1, a_reg=3, a_data=0x1234 for one cycle -> busy[3]=1 after edge 1; rw=1, wr=3, wv=0x1234 after edge 2; busy[3]=0 after edge 3.
REQ-026 m_valid=1, m_reg=31, m_data=0xFF -> accepted (m_ready stays 1), rw never asserts, busy stays 0.
REQ-027 Same-edge accept A(reg 5, 0xA) and M(reg 6, 0xB) -> with macro: writes reg 5 then reg 6 on consecutive cycles; without: reg 6 then reg 5.
REQ-028 A writes reg 7 (0x1), then a new A request to reg 7 (0x2) is accepted on the edge where the first rw=1 commits -> busy[7] remains 1 until the second write commits.
REQ-029 Both requesters valid continuously, reg 1/2 -> rw=1 every cycle, a_ready and m_ready each low every other cycle, no request lost.
REQ-030 Assert reset while both buffers are full and rw=1 -> rw, busy and outputs go 0 immediately; neither buffered write ever appears on wr/wv.
